// File: rtl/sr_flag_bank_pkg.sv
// Shared encodings and helpers for the synchronised set/reset flag bank.
// Imported by the per-channel slice and the bank top level.
package sr_flag_bank_pkg;

    localparam logic EDGE    = 1'b1;
    localparam logic LEVEL   = 1'b0;
    localparam logic SET_DOM = 1'b1;
    localparam logic RST_DOM = 1'b0;

    localparam int unsigned MaxSyncStages = 3;
    localparam int unsigned MaxCntW       = 16;

    // True when the low cnt_w bits of cnt are all ones.
    function automatic logic cnt_saturated(input logic [MaxCntW-1:0] cnt,
                                           input int unsigned        cnt_w);
        logic [MaxCntW-1:0] ones;
        ones = {MaxCntW{1'b1}} >> (MaxCntW - cnt_w);
        return cnt == ones;
    endfunction

endpackage

// File: rtl/sr_flag_bank_chan.sv
// One flag channel: s/r synchroniser, edge history, prioritised flag,
// change pulse and saturating set-event counter.
module sr_flag_chan
    import sr_flag_bank_pkg::*;
#(
    parameter int unsigned SyncStages = 2,
    parameter int unsigned CntW       = 4
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            enable_i,
    input  logic            clr_all_i,
    input  logic            s_i,
    input  logic            r_i,
    input  logic            edge_mode_i,
    input  logic            set_dom_i,
    input  logic            cnt_clr_i,
    output logic            q_o,
    output logic            changed_o,
    output logic [CntW-1:0] cnt_o
);

    logic            s_sync, r_sync;
    logic            s_prev_q, r_prev_q;
    logic            ts, tr;
    logic            q_q, q_d;
    logic            changed_q;
    logic [CntW-1:0] cnt_q, cnt_d;

    if (SyncStages == 0) begin : g_bypass
        assign s_sync = s_i;
        assign r_sync = r_i;
    end else begin : g_sync
        logic [SyncStages-1:0] s_pipe_q, r_pipe_q;

        always_ff @(posedge clk_i or negedge rst_ni) begin
            if (!rst_ni) begin
                s_pipe_q <= '0;
                r_pipe_q <= '0;
            end else begin
                s_pipe_q <= (s_pipe_q << 1) | SyncStages'(s_i);
                r_pipe_q <= (r_pipe_q << 1) | SyncStages'(r_i);
            end
        end

        assign s_sync = s_pipe_q[SyncStages-1];
        assign r_sync = r_pipe_q[SyncStages-1];
    end

    always_comb begin
        ts = s_sync;
        tr = r_sync;
        if (edge_mode_i == EDGE) begin
            ts = s_sync & ~s_prev_q;
            tr = r_sync & ~r_prev_q;
        end

        q_d = q_q;
        if (clr_all_i) begin
            q_d = 1'b0;
        end else if (enable_i) begin
            if (ts && tr) begin
                q_d = (set_dom_i == SET_DOM);
            end else if (ts) begin
                q_d = 1'b1;
            end else if (tr) begin
                q_d = 1'b0;
            end
        end

        // cnt_clr beats a same-cycle increment; saturate instead of wrapping.
        cnt_d = cnt_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (q_d && !q_q && !cnt_saturated(MaxCntW'(cnt_q), CntW)) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            s_prev_q  <= 1'b0;
            r_prev_q  <= 1'b0;
            q_q       <= 1'b0;
            changed_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            s_prev_q  <= s_sync;
            r_prev_q  <= r_sync;
            q_q       <= q_d;
            changed_q <= q_d ^ q_q;
            cnt_q     <= cnt_d;
        end
    end

    assign q_o       = q_q;
    assign changed_o = changed_q;
    assign cnt_o     = cnt_q;

endmodule

// File: rtl/sr_flag_bank.sv
// Bank of WIDTH synchronised set/reset flags with per-channel counters
// and a masked, registered interrupt summary.
module sr_flag_bank
    import sr_flag_bank_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned CNT_W       = 4
) (
    input  logic                   clk,
    input  logic                   reset_triggerN,
    input  logic                   enable,
    input  logic                   clr_all,
    input  logic [WIDTH-1:0]       s,
    input  logic [WIDTH-1:0]       r,
    input  logic [WIDTH-1:0]       edge_mode,
    input  logic [WIDTH-1:0]       set_dom,
    input  logic [WIDTH-1:0]       irq_mask,
    input  logic                   cnt_clr,
    output logic [WIDTH-1:0]       q,
    output logic [WIDTH-1:0]       qN,
    output logic [WIDTH-1:0]       changed,
    output logic [WIDTH*CNT_W-1:0] set_cnt,
    output logic                   irq
);

    logic irq_q;

    for (genvar i = 0; i < WIDTH; i++) begin : g_chan
        sr_flag_chan #(
            .SyncStages (SYNC_STAGES),
            .CntW       (CNT_W)
        ) u_chan (
            .clk_i       (clk),
            .rst_ni      (reset_triggerN),
            .enable_i    (enable),
            .clr_all_i   (clr_all),
            .s_i         (s[i]),
            .r_i         (r[i]),
            .edge_mode_i (edge_mode[i]),
            .set_dom_i   (set_dom[i]),
            .cnt_clr_i   (cnt_clr),
            .q_o         (q[i]),
            .changed_o   (changed[i]),
            .cnt_o       (set_cnt[i*CNT_W +: CNT_W])
        );
    end

    always_ff @(posedge clk or negedge reset_triggerN) begin
        if (!reset_triggerN) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= |(q & irq_mask);
        end
    end

    assign qN  = ~q;
    assign irq = irq_q;

endmodule
